hd44780_lcd_sequencer: RTL and testbench

Controller that owns the hd44780_nybble_sender and drives it through the HD44780 4-bit power-on initialization, then accepts host byte writes. Each byte is split into two nybbles, and the sequencer enforces the post-command execution delays. It sits between the top-level test logic or host and the nybble sender, and runs on wb_clk from hd44780_syscon. The delay counter is internal, so no external state timer is needed.

---
 rtl/hd44780_lcd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_hd44780_lcd_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_lcd_sequencer.sv
// HD44780 4-bit sequencer: runs the power-on init sequence through the nybble
// sender, then splits host bytes into nybble pairs and enforces the
// execution delay after each command or data byte.
module hd44780_lcd_sequencer #(
    parameter int TIMER_BITS  = 20,
    parameter int DLY_POWERUP = 600000,
    parameter int DLY_4P1MS   = 24600,
    parameter int DLY_100US   = 600,
    parameter int DLY_CMD     = 318,
    parameter int DLY_CLEAR   = 18000
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_ns_stb,
    output logic       o_ns_rs,
    output logic [3:0] o_ns_nybble,
    input  logic       i_ns_busy
);

    typedef enum logic [2:0] {PWRUP, NYB_SEND, NYB_WAIT1, NYB_WAIT, DELAY, IDLE} state_t;
    typedef enum logic [1:0] {DSEL_CMD, DSEL_4P1MS, DSEL_100US, DSEL_CLEAR} dsel_t;

    typedef struct packed {
        logic [3:0] nybble;
        logic       rs;
        logic       last;   // a delay follows this nybble
        dsel_t      dsel;
    } rom_entry_t;

    // Final entry of the init ROM (0x0C low nybble)
    localparam logic [3:0] LAST_STEP = 4'd13;

    // Init sequence: four single wake-up nybbles, then five bytes as hi/lo pairs
    function automatic rom_entry_t seq_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    seq_rom = '{4'h3, 1'b0, 1'b1, DSEL_4P1MS};
            4'd1:    seq_rom = '{4'h3, 1'b0, 1'b1, DSEL_100US};
            4'd2:    seq_rom = '{4'h3, 1'b0, 1'b1, DSEL_CMD};
            4'd3:    seq_rom = '{4'h2, 1'b0, 1'b1, DSEL_CMD};
            4'd4:    seq_rom = '{4'h2, 1'b0, 1'b0, DSEL_CMD};
            4'd5:    seq_rom = '{4'h8, 1'b0, 1'b1, DSEL_CMD};
            4'd6:    seq_rom = '{4'h0, 1'b0, 1'b0, DSEL_CMD};
            4'd7:    seq_rom = '{4'h8, 1'b0, 1'b1, DSEL_CMD};
            4'd8:    seq_rom = '{4'h0, 1'b0, 1'b0, DSEL_CMD};
            4'd9:    seq_rom = '{4'h1, 1'b0, 1'b1, DSEL_CLEAR};
            4'd10:   seq_rom = '{4'h0, 1'b0, 1'b0, DSEL_CMD};
            4'd11:   seq_rom = '{4'h6, 1'b0, 1'b1, DSEL_CMD};
            4'd12:   seq_rom = '{4'h0, 1'b0, 1'b0, DSEL_CMD};
            4'd13:   seq_rom = '{4'hC, 1'b0, 1'b1, DSEL_CMD};
            default: seq_rom = '{4'h0, 1'b0, 1'b1, DSEL_CMD};
        endcase
    endfunction

    function automatic logic [TIMER_BITS-1:0] dly_ticks(input dsel_t d);
        case (d)
            DSEL_4P1MS: dly_ticks = TIMER_BITS'(DLY_4P1MS);
            DSEL_100US: dly_ticks = TIMER_BITS'(DLY_100US);
            DSEL_CLEAR: dly_ticks = TIMER_BITS'(DLY_CLEAR);
            default:    dly_ticks = TIMER_BITS'(DLY_CMD);
        endcase
    endfunction

    state_t                  state_reg, state_next;
    logic [TIMER_BITS-1:0]   cnt_reg, cnt_next;
    logic [3:0]              step_reg, step_next;
    logic                    phase_reg, phase_next;      // 0: high nybble of host byte in flight
    logic [7:0]              byte_reg, byte_next;
    logic                    rs_reg, rs_next;
    logic [3:0]              nyb_reg, nyb_next;
    logic                    ns_rs_reg, ns_rs_next;
    logic                    init_done_reg, init_done_next;

    rom_entry_t cur_entry, nxt_entry;
    logic       host_clear;

    assign cur_entry = seq_rom(step_reg);
    assign nxt_entry = seq_rom(step_reg + 4'd1);

    // Clear and home commands need the long execution delay
    assign host_clear = !rs_reg && (byte_reg == 8'h01 || byte_reg == 8'h02 || byte_reg == 8'h03);

    assign o_busy      = (state_reg != IDLE);
    assign o_init_done = init_done_reg;
    assign o_ns_stb    = (state_reg == NYB_SEND) && !i_ns_busy;
    assign o_ns_rs     = ns_rs_reg;
    assign o_ns_nybble = nyb_reg;

    // State and datapath registers; reset restarts the whole init sequence
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg     <= PWRUP;
            cnt_reg       <= TIMER_BITS'(DLY_POWERUP);
            step_reg      <= 4'd0;
            phase_reg     <= 1'b0;
            byte_reg      <= 8'h00;
            rs_reg        <= 1'b0;
            nyb_reg       <= 4'h0;
            ns_rs_reg     <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            step_reg      <= step_next;
            phase_reg     <= phase_next;
            byte_reg      <= byte_next;
            rs_reg        <= rs_next;
            nyb_reg       <= nyb_next;
            ns_rs_reg     <= ns_rs_next;
            init_done_reg <= init_done_next;
        end
    end

    // Next-state logic: nybble/rs are loaded on entry to NYB_SEND so they are
    // already valid in the strobe cycle and held until the next strobe
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        step_next      = step_reg;
        phase_next     = phase_reg;
        byte_next      = byte_reg;
        rs_next        = rs_reg;
        nyb_next       = nyb_reg;
        ns_rs_next     = ns_rs_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            PWRUP: begin
                if (cnt_reg == '0) begin
                    state_next = NYB_SEND;
                    nyb_next   = cur_entry.nybble;
                    ns_rs_next = cur_entry.rs;
                end else begin
                    cnt_next = cnt_reg - TIMER_BITS'(1);
                end
            end
            NYB_SEND: begin
                if (!i_ns_busy) state_next = NYB_WAIT1;
            end
            NYB_WAIT1: begin
                // sender may take one cycle to raise busy
                state_next = NYB_WAIT;
            end
            NYB_WAIT: begin
                if (!i_ns_busy) begin
                    if (init_done_reg) begin
                        if (!phase_reg) begin
                            phase_next = 1'b1;
                            nyb_next   = byte_reg[3:0];
                            state_next = NYB_SEND;
                        end else begin
                            state_next = DELAY;
                            cnt_next   = host_clear ? TIMER_BITS'(DLY_CLEAR) : TIMER_BITS'(DLY_CMD);
                        end
                    end else if (cur_entry.last) begin
                        state_next = DELAY;
                        cnt_next   = dly_ticks(cur_entry.dsel);
                    end else begin
                        step_next  = step_reg + 4'd1;
                        nyb_next   = nxt_entry.nybble;
                        ns_rs_next = nxt_entry.rs;
                        state_next = NYB_SEND;
                    end
                end
            end
            DELAY: begin
                if (cnt_reg == '0) begin
                    if (init_done_reg) begin
                        state_next = IDLE;
                    end else if (step_reg == LAST_STEP) begin
                        state_next     = IDLE;
                        init_done_next = 1'b1;
                    end else begin
                        step_next  = step_reg + 4'd1;
                        nyb_next   = nxt_entry.nybble;
                        ns_rs_next = nxt_entry.rs;
                        state_next = NYB_SEND;
                    end
                end else begin
                    cnt_next = cnt_reg - TIMER_BITS'(1);
                end
            end
            IDLE: begin
                if (STB_I) begin
                    byte_next  = i_byte;
                    rs_next    = i_rs;
                    nyb_next   = i_byte[7:4];
                    ns_rs_next = i_rs;
                    phase_next = 1'b0;
                    state_next = NYB_SEND;
                end
            end
            default: state_next = PWRUP;
        endcase
    end

endmodule

// File: tb/tb_hd44780_lcd_sequencer.sv
// Directed bench for hd44780_lcd_sequencer with a 4-cycle-busy nybble sender model.
module tb_hd44780_lcd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stb = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       busy, init_done, ns_stb, ns_rs, ns_busy;
    logic [3:0] ns_nyb;

    always #5 clk = ~clk;

    hd44780_lcd_sequencer #(
        .TIMER_BITS(8), .DLY_POWERUP(20), .DLY_4P1MS(10),
        .DLY_100US(5), .DLY_CMD(3), .DLY_CLEAR(8)
    ) dut (
        .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .i_rs(rs), .i_byte(byte_in),
        .o_busy(busy), .o_init_done(init_done), .o_ns_stb(ns_stb),
        .o_ns_rs(ns_rs), .o_ns_nybble(ns_nyb), .i_ns_busy(ns_busy)
    );

    // Hand-computed init nybbles and strobe-to-strobe gaps (index 0 unused)
    localparam int EXP_NYB [14] = '{3, 3, 3, 2, 2, 8, 0, 8, 0, 1, 0, 6, 0, 12};
    localparam int EXP_GAP [14] = '{0, 17, 12, 10, 10, 6, 10, 6, 10, 6, 15, 6, 10, 6};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int long_hold_idx = -1;
    int stb_while_busy = 0;
    int stb_cyc_q[$];
    int stb_nyb_q[$];
    int stb_rs_q[$];
    int done_cyc = 0;
    logic done_busy = 1'b1;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sender model: busy for 4 cycles (or 50 on the selected strobe) after each strobe
    assign ns_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (ns_stb)
            busy_cnt <= (stb_cyc_q.size() - 1 == long_hold_idx) ? 50 : 4;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end

    // Strobe and init_done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (ns_stb === 1'b1) begin
            stb_cyc_q.push_back(cyc);
            stb_nyb_q.push_back(int'(ns_nyb));
            stb_rs_q.push_back(int'(ns_rs));
            if (ns_busy) stb_while_busy++;
        end
        if (init_done === 1'b1 && !done_prev) begin
            done_cyc  = cyc;
            done_busy = busy;
        end
        done_prev = (init_done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        stb_cyc_q.delete();
        stb_nyb_q.delete();
        stb_rs_q.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, busy, 1);
        check({pfx, "_init_done"}, init_done, 0);
        check({pfx, "_ns_stb"}, ns_stb, 0);
        check({pfx, "_ns_rs"}, ns_rs, 0);
        check({pfx, "_ns_nybble"}, ns_nyb, 0);
    endtask

    // Wait (bounded) for init completion; optionally pulse STB_I at wait cycle poke
    task automatic wait_init(input int poke);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            stb = (n == poke);
            rs = 1'b1;
            byte_in = 8'hFF;
            @(negedge clk);
            n++;
        end
        stb = 1'b0;
        #1;
        check("init_done_reached", init_done, 1);
    endtask

    task automatic check_init_seq(input string pfx, input int rel, input int hold);
        int exp_gap;
        check({pfx, "_strobe_count"}, stb_cyc_q.size(), 14);
        if (stb_cyc_q.size() > 0)
            check({pfx, "_first_latency"}, stb_cyc_q[0] - rel, 21);
        for (int i = 0; i < 14 && i < stb_cyc_q.size(); i++) begin
            check($sformatf("%s_nyb%0d", pfx, i), stb_nyb_q[i], EXP_NYB[i]);
            check($sformatf("%s_rs%0d", pfx, i), stb_rs_q[i], 0);
            if (i > 0) begin
                exp_gap = (hold != 0 && i == 6) ? 56 : EXP_GAP[i];
                check($sformatf("%s_gap%0d", pfx, i), stb_cyc_q[i] - stb_cyc_q[i-1], exp_gap);
            end
        end
        if (stb_cyc_q.size() >= 14)
            check({pfx, "_done_latency"}, done_cyc - stb_cyc_q[13], 10);
        check({pfx, "_busy_at_done"}, done_busy, 0);
    endtask

    // One host write from IDLE; counts cycles with o_busy high, pokes STB_I at busy cycle poke
    task automatic host_write(input logic r, input logic [7:0] b, input int poke, output int busy_cycles);
        int n;
        stb = 1'b1;
        rs = r;
        byte_in = b;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            stb = (n == poke);
            if (n == poke) byte_in = 8'h99;
            n++;
            @(negedge clk);
        end
        stb = 1'b0;
        busy_cycles = n;
    endtask

    int rel;
    int bc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Init from reset release, with a dropped STB_I pulse mid-init
        rst_n = 1'b1;
        rel = cyc;
        wait_init(30);
        check_init_seq("init", rel, 0);

        // Data write 0x41, with a second request dropped while busy
        repeat (3) @(negedge clk);
        #1;
        clear_log();
        host_write(1'b1, 8'h41, 3, bc);
        check("wr41_busy_cycles", bc, 16);
        repeat (30) @(negedge clk);
        #1;
        check("wr41_strobe_count", stb_cyc_q.size(), 2);
        if (stb_cyc_q.size() >= 2) begin
            check("wr41_hi", stb_nyb_q[0], 4);
            check("wr41_lo", stb_nyb_q[1], 1);
            check("wr41_rs_hi", stb_rs_q[0], 1);
            check("wr41_rs_lo", stb_rs_q[1], 1);
            check("wr41_gap", stb_cyc_q[1] - stb_cyc_q[0], 6);
        end

        // Clear command takes the long delay; same byte as data does not
        clear_log();
        host_write(1'b0, 8'h01, -1, bc);
        check("clr_busy_cycles", bc, 21);
        #1;
        if (stb_cyc_q.size() >= 2) begin
            check("clr_hi", stb_nyb_q[0], 0);
            check("clr_lo", stb_nyb_q[1], 1);
            check("clr_rs", stb_rs_q[1], 0);
        end
        host_write(1'b1, 8'h01, -1, bc);
        check("data01_busy_cycles", bc, 16);
        host_write(1'b0, 8'h03, -1, bc);
        check("home03_busy_cycles", bc, 21);
        host_write(1'b0, 8'h04, -1, bc);
        check("cmd04_busy_cycles", bc, 16);

        // Reset between the high and low nybble of a byte
        clear_log();
        stb = 1'b1;
        rs = 1'b1;
        byte_in = 8'h55;
        @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_hi_nybble", ns_nyb, 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        clear_log();
        long_hold_idx = 5;

        // Full replay with a 50-cycle busy on strobe 5
        rst_n = 1'b1;
        rel = cyc;
        wait_init(-1);
        check_init_seq("replay", rel, 1);
        check("strobe_while_busy", stb_while_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
